branch_predict_ctrl: RTL

- Bimodal branch predictor and redirect controller for the fetch PC register.
- Fetch side: a direct-mapped table of 2-bit counters, tags and targets produces the fetch-stage taken/target select for the PC mux.
- Decode side: compares the prediction carried with the instruction against the branch outcome resolved in decode, issues a correction redirect (PC mux priority select), and trains the table.

---
 rtl/branch_predict_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor and decode-stage redirect controller.
// Fetch side: direct-mapped table of 2-bit counters, tags and targets feeds
// the fetch PC mux taken/target select. Decode side: checks the prediction
// that travelled with the instruction against the resolved outcome, raises
// a priority correction redirect and trains the table.
module branch_predict_ctrl #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:0] iPCF,
    input  logic        iStallF,
    output logic        oPredTakenF,
    output logic [31:0] oPredTargetF,
    input  logic        iBranchD,
    input  logic [31:0] iPCD,
    input  logic        iTakenD,
    input  logic [31:0] iTargetD,
    output logic        oRedirectD,
    output logic [31:0] oRedirectPC,
    output logic [15:0] oMispredCnt
);

    // Per-entry direction state: predict taken in WT/ST.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Table storage
    logic [ENTRIES-1:0]            r_valid;
    ctr_t                          r_ctr [ENTRIES];
    logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
    logic [ENTRIES-1:0][31:0]      r_tgt;

    // Prediction carried alongside the instruction into decode
    logic        r_predTakenD;
    logic [31:0] r_predTargetD;
    logic [15:0] r_mispredCnt;

    // Fetch lookup
    logic [IDX_W-1:0] w_fIdx;
    logic [TAG_W-1:0] w_fTag;
    logic             w_fHit;

    // Decode resolve / training
    logic [IDX_W-1:0] w_dIdx;
    logic [TAG_W-1:0] w_dTag;
    logic             w_dHit;
    logic             w_train;
    logic             w_alloc;
    logic             w_update;
    ctr_t             w_ctrCur;
    ctr_t             w_ctrNext;
    logic             w_redirect;
    logic [31:0]      w_redirectPC;

    assign w_fIdx = iPCF[IDX_W+1:2];
    assign w_fTag = iPCF[TAG_W+IDX_W+1:IDX_W+2];
    assign w_dIdx = iPCD[IDX_W+1:2];
    assign w_dTag = iPCD[TAG_W+IDX_W+1:IDX_W+2];

    // Fetch lookup reads the table as it stood before this cycle's training.
    assign w_fHit       = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
    assign oPredTakenF  = w_fHit && r_ctr[w_fIdx][1] && !w_redirect;
    assign oPredTargetF = w_fHit ? r_tgt[w_fIdx] : 32'h0;

    // Misprediction detection; held quiet while reset is asserted.
    always_comb begin
        w_redirect   = 1'b0;
        w_redirectPC = 32'h0;
        if (iRstN && iBranchD) begin
            if (iTakenD && (!r_predTakenD || (r_predTargetD != iTargetD))) begin
                w_redirect   = 1'b1;
                w_redirectPC = iTargetD;
            end else if (!iTakenD && r_predTakenD) begin
                w_redirect   = 1'b1;
                w_redirectPC = iPCD + 32'd4;
            end
        end
    end

    assign oRedirectD  = w_redirect;
    assign oRedirectPC = w_redirectPC;
    assign oMispredCnt = r_mispredCnt;

    // Training qualifiers: hits update, taken misses allocate, other misses drop.
    assign w_dHit   = r_valid[w_dIdx] && (r_tag[w_dIdx] == w_dTag);
    assign w_train  = iBranchD && !iStallF;
    assign w_update = w_train && w_dHit;
    assign w_alloc  = w_train && !w_dHit && iTakenD;
    assign w_ctrCur = r_ctr[w_dIdx];

    // Saturating counter next state for the entry being trained.
    always_comb begin
        w_ctrNext = w_ctrCur;
        if (w_alloc) begin
            w_ctrNext = WT;
        end else begin
            unique case (w_ctrCur)
                SNT: w_ctrNext = iTakenD ? WNT : SNT;
                WNT: w_ctrNext = iTakenD ? WT  : SNT;
                WT:  w_ctrNext = iTakenD ? ST  : WNT;
                ST:  w_ctrNext = iTakenD ? ST  : WT;
                default: w_ctrNext = WNT;
            endcase
        end
    end

    // Table state registers; only the decode-indexed entry can change.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_valid <= '0;
            r_tag   <= '0;
            r_tgt   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (w_update || w_alloc) begin
            r_ctr[w_dIdx] <= w_ctrNext;
            if (w_alloc) begin
                r_valid[w_dIdx] <= 1'b1;
                r_tag[w_dIdx]   <= w_dTag;
            end
            if (iTakenD) begin
                r_tgt[w_dIdx] <= iTargetD;
            end
        end
    end

    // Decode prediction register; a redirect flushes decode to a bubble.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_predTakenD  <= 1'b0;
            r_predTargetD <= 32'h0;
        end else if (!iStallF) begin
            if (w_redirect) begin
                r_predTakenD  <= 1'b0;
                r_predTargetD <= 32'h0;
            end else begin
                r_predTakenD  <= oPredTakenF;
                r_predTargetD <= oPredTargetF;
            end
        end
    end

    // Saturating mispredict counter, counts only redirects that take effect.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_mispredCnt <= 16'h0;
        end else if (w_redirect && !iStallF && (r_mispredCnt != 16'hFFFF)) begin
            r_mispredCnt <= r_mispredCnt + 16'd1;
        end
    end

endmodule
